// File: rtl/decode_cycle.sv
// Decode stage of the 5-stage RV32I pipeline.
// Decodes InstrD, reads the register file (with a same-cycle W->D bypass),
// sign-extends the immediate and registers everything into the ID/EX register.
module decode_cycle #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     InstrD,
    input  logic [XLEN-1:0] PCD,
    input  logic [XLEN-1:0] PCPlus4D,
    input  logic            RegWriteW,
    input  logic [4:0]      RDW,
    input  logic [XLEN-1:0] ResultW,
    input  logic            FlushE,
    output logic            RegWriteE,
    output logic [1:0]      ResultSrcE,
    output logic            MemWriteE,
    output logic            JumpE,
    output logic            BranchE,
    output logic [2:0]      ALUControlE,
    output logic            ALUSrcE,
    output logic [XLEN-1:0] RD1E,
    output logic [XLEN-1:0] RD2E,
    output logic [XLEN-1:0] ImmExtE,
    output logic [4:0]      Rs1E,
    output logic [4:0]      Rs2E,
    output logic [4:0]      RdE,
    output logic [XLEN-1:0] PCE,
    output logic [XLEN-1:0] PCPlus4E,
    output logic [4:0]      Rs1D,
    output logic [4:0]      Rs2D
);

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_J
    } imm_src_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            funct7b5;
    logic [4:0]      rd;

    logic            reg_write;
    imm_src_t        imm_src;
    logic            alu_src;
    logic            mem_write;
    logic [1:0]      result_src;
    logic            branch;
    logic [1:0]      alu_op;
    logic            jump;
    logic [2:0]      alu_control;
    logic [XLEN-1:0] imm_ext;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic            wb_active;

    logic [XLEN-1:0] rf [NREGS];

    assign opcode   = InstrD[6:0];
    assign funct3   = InstrD[14:12];
    assign funct7b5 = InstrD[30];
    assign rd       = InstrD[11:7];
    assign Rs1D     = InstrD[19:15];
    assign Rs2D     = InstrD[24:20];

    // Main decoder: opcode to control bundle; unknown opcodes decode as a bubble
    always_comb begin
        reg_write  = 1'b0;
        imm_src    = IMM_NONE;
        alu_src    = 1'b0;
        mem_write  = 1'b0;
        result_src = 2'b00;
        branch     = 1'b0;
        alu_op     = 2'b00;
        jump       = 1'b0;
        case (opcode)
            OP_LOAD: begin
                reg_write  = 1'b1;
                imm_src    = IMM_I;
                alu_src    = 1'b1;
                result_src = 2'b01;
            end
            OP_STORE: begin
                imm_src    = IMM_S;
                alu_src    = 1'b1;
                mem_write  = 1'b1;
            end
            OP_RTYPE: begin
                reg_write  = 1'b1;
                alu_op     = 2'b10;
            end
            OP_IALU: begin
                reg_write  = 1'b1;
                imm_src    = IMM_I;
                alu_src    = 1'b1;
                alu_op     = 2'b10;
            end
            OP_BRANCH: begin
                imm_src    = IMM_B;
                branch     = 1'b1;
                alu_op     = 2'b01;
            end
            OP_JAL: begin
                reg_write  = 1'b1;
                imm_src    = IMM_J;
                result_src = 2'b10;
                jump       = 1'b1;
            end
            default: begin
                reg_write  = 1'b0;
            end
        endcase
    end

    // ALU decoder: subtract only for R-type sub, other funct3 fall back to add
    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            2'b00: alu_control = ALU_ADD;
            2'b01: alu_control = ALU_SUB;
            2'b10: begin
                case (funct3)
                    3'b000:  alu_control = (opcode[5] & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

    // Immediate extension, sign always taken from bit 31
    always_comb begin
        imm_ext = '0;
        case (imm_src)
            IMM_I: imm_ext = {{(XLEN-12){InstrD[31]}}, InstrD[31:20]};
            IMM_S: imm_ext = {{(XLEN-12){InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
            IMM_B: imm_ext = {{(XLEN-12){InstrD[31]}}, InstrD[7], InstrD[30:25],
                              InstrD[11:8], 1'b0};
            IMM_J: imm_ext = {{(XLEN-20){InstrD[31]}}, InstrD[19:12], InstrD[20],
                              InstrD[30:21], 1'b0};
            default: imm_ext = '0;
        endcase
    end

    // Register read with x0 hardwired to zero and same-cycle writeback bypass
    always_comb begin
        wb_active = RegWriteW && (RDW != 5'd0);
        rd1 = '0;
        rd2 = '0;
        if (Rs1D != 5'd0) begin
            rd1 = (wb_active && RDW == Rs1D) ? ResultW : rf[Rs1D];
        end
        if (Rs2D != 5'd0) begin
            rd2 = (wb_active && RDW == Rs2D) ? ResultW : rf[Rs2D];
        end
    end

    // Register file write port; reset wipes every entry and drops a pending write
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                rf[i] <= '0;
            end
        end else if (RegWriteW && RDW != 5'd0) begin
            rf[RDW] <= ResultW;
        end
    end

    // ID/EX pipeline register: reset beats flush, flush beats a normal load
    always_ff @(posedge clk) begin
        if (rst || FlushE) begin
            RegWriteE   <= 1'b0;
            ResultSrcE  <= 2'b00;
            MemWriteE   <= 1'b0;
            JumpE       <= 1'b0;
            BranchE     <= 1'b0;
            ALUControlE <= 3'b000;
            ALUSrcE     <= 1'b0;
            RD1E        <= '0;
            RD2E        <= '0;
            ImmExtE     <= '0;
            Rs1E        <= 5'd0;
            Rs2E        <= 5'd0;
            RdE         <= 5'd0;
            PCE         <= '0;
            PCPlus4E    <= '0;
        end else begin
            RegWriteE   <= reg_write;
            ResultSrcE  <= result_src;
            MemWriteE   <= mem_write;
            JumpE       <= jump;
            BranchE     <= branch;
            ALUControlE <= alu_control;
            ALUSrcE     <= alu_src;
            RD1E        <= rd1;
            RD2E        <= rd2;
            ImmExtE     <= imm_ext;
            Rs1E        <= Rs1D;
            Rs2E        <= Rs2D;
            RdE         <= rd;
            PCE         <= PCD;
            PCPlus4E    <= PCPlus4D;
        end
    end

endmodule

// File: tb/tb_decode_cycle.sv
// Self-checking bench for decode_cycle: a reference model predicts the ID/EX
// contents for each driven instruction, pushes them to a queue, and the
// prediction is popped and compared one cycle later.
module tb_decode_cycle;

    logic        clk;
    logic        rst;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        RegWriteW;
    logic [4:0]  RDW;
    logic [31:0] ResultW;
    logic        FlushE;
    logic        RegWriteE;
    logic [1:0]  ResultSrcE;
    logic        MemWriteE;
    logic        JumpE;
    logic        BranchE;
    logic [2:0]  ALUControlE;
    logic        ALUSrcE;
    logic [31:0] RD1E;
    logic [31:0] RD2E;
    logic [31:0] ImmExtE;
    logic [4:0]  Rs1E;
    logic [4:0]  Rs2E;
    logic [4:0]  RdE;
    logic [31:0] PCE;
    logic [31:0] PCPlus4E;
    logic [4:0]  Rs1D;
    logic [4:0]  Rs2D;

    typedef struct packed {
        logic        reg_write;
        logic [1:0]  result_src;
        logic        mem_write;
        logic        jump;
        logic        branch;
        logic [2:0]  alu_control;
        logic        alu_src;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
    } expect_t;

    expect_t     scoreboard[$];
    logic [31:0] model_rf [32];
    logic [31:0] next_pc;
    int          checks_total;
    int          checks_passed;

    decode_cycle #(.XLEN(32), .NREGS(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .InstrD     (InstrD),
        .PCD        (PCD),
        .PCPlus4D   (PCPlus4D),
        .RegWriteW  (RegWriteW),
        .RDW        (RDW),
        .ResultW    (ResultW),
        .FlushE     (FlushE),
        .RegWriteE  (RegWriteE),
        .ResultSrcE (ResultSrcE),
        .MemWriteE  (MemWriteE),
        .JumpE      (JumpE),
        .BranchE    (BranchE),
        .ALUControlE(ALUControlE),
        .ALUSrcE    (ALUSrcE),
        .RD1E       (RD1E),
        .RD2E       (RD2E),
        .ImmExtE    (ImmExtE),
        .Rs1E       (Rs1E),
        .Rs2E       (Rs2E),
        .RdE        (RdE),
        .PCE        (PCE),
        .PCPlus4E   (PCPlus4E),
        .Rs1D       (Rs1D),
        .Rs2D       (Rs2D)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks_total++;
        if (actual === expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    function automatic logic [31:0] modelRead(input logic [4:0] idx, input logic wen,
                                              input logic [4:0] rdw, input logic [31:0] res);
        if (idx == 5'd0) return 32'd0;
        if (wen && rdw == idx) return res;
        return model_rf[idx];
    endfunction

    function automatic logic [2:0] modelAluFunct(input logic [2:0] f3, input logic is_sub);
        case (f3)
            3'b000:  return is_sub ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    // Predict the ID/EX contents for one instruction given the current model state
    function automatic expect_t modelDecode(input logic [31:0] instr, input logic [31:0] pc,
                                            input logic wen, input logic [4:0] rdw,
                                            input logic [31:0] res);
        expect_t e;
        logic signed [11:0] imm12;
        logic signed [12:0] imm13;
        logic signed [20:0] imm21;
        e = '0;
        e.rs1      = instr[19:15];
        e.rs2      = instr[24:20];
        e.rd       = instr[11:7];
        e.pc       = pc;
        e.pc_plus4 = pc + 32'd4;
        e.rd1      = modelRead(instr[19:15], wen, rdw, res);
        e.rd2      = modelRead(instr[24:20], wen, rdw, res);
        case (instr[6:0])
            7'b0000011: begin
                e.reg_write = 1'b1; e.alu_src = 1'b1; e.result_src = 2'b01;
                imm12 = instr[31:20]; e.imm = 32'(imm12);
            end
            7'b0100011: begin
                e.alu_src = 1'b1; e.mem_write = 1'b1;
                imm12 = {instr[31:25], instr[11:7]}; e.imm = 32'(imm12);
            end
            7'b0110011: begin
                e.reg_write = 1'b1;
                e.alu_control = modelAluFunct(instr[14:12], instr[30]);
            end
            7'b0010011: begin
                e.reg_write = 1'b1; e.alu_src = 1'b1;
                e.alu_control = modelAluFunct(instr[14:12], 1'b0);
                imm12 = instr[31:20]; e.imm = 32'(imm12);
            end
            7'b1100011: begin
                e.branch = 1'b1; e.alu_control = 3'b001;
                imm13 = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
                e.imm = 32'(imm13);
            end
            7'b1101111: begin
                e.reg_write = 1'b1; e.jump = 1'b1; e.result_src = 2'b10;
                imm21 = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
                e.imm = 32'(imm21);
            end
            default: e.imm = 32'd0;
        endcase
        return e;
    endfunction

    // Drive one decode cycle, predict its result, then compare after the edge
    task automatic applyStimulus(input logic [31:0] instr, input logic wen,
                                 input logic [4:0] rdw, input logic [31:0] res,
                                 input logic flush, input logic rst_in);
        expect_t e;
        expect_t got;
        @(negedge clk);
        InstrD    = instr;
        PCD       = next_pc;
        PCPlus4D  = next_pc + 32'd4;
        RegWriteW = wen;
        RDW       = rdw;
        ResultW   = res;
        FlushE    = flush;
        rst       = rst_in;
        #1;
        checkOutput("Rs1D", 32'(Rs1D), 32'(instr[19:15]));
        checkOutput("Rs2D", 32'(Rs2D), 32'(instr[24:20]));
        if (rst_in || flush) e = '0;
        else e = modelDecode(instr, next_pc, wen, rdw, res);
        scoreboard.push_back(e);
        next_pc = next_pc + 32'd4;
        @(posedge clk);
        #1;
        e = scoreboard.pop_front();
        got = '{RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUControlE, ALUSrcE,
                RD1E, RD2E, ImmExtE, Rs1E, Rs2E, RdE, PCE, PCPlus4E};
        checkOutput("RegWriteE",   32'(got.reg_write),   32'(e.reg_write));
        checkOutput("ResultSrcE",  32'(got.result_src),  32'(e.result_src));
        checkOutput("MemWriteE",   32'(got.mem_write),   32'(e.mem_write));
        checkOutput("JumpE",       32'(got.jump),        32'(e.jump));
        checkOutput("BranchE",     32'(got.branch),      32'(e.branch));
        checkOutput("ALUControlE", 32'(got.alu_control), 32'(e.alu_control));
        checkOutput("ALUSrcE",     32'(got.alu_src),     32'(e.alu_src));
        checkOutput("RD1E",        got.rd1,              e.rd1);
        checkOutput("RD2E",        got.rd2,              e.rd2);
        checkOutput("ImmExtE",     got.imm,              e.imm);
        checkOutput("Rs1E",        32'(got.rs1),         32'(e.rs1));
        checkOutput("Rs2E",        32'(got.rs2),         32'(e.rs2));
        checkOutput("RdE",         32'(got.rd),          32'(e.rd));
        checkOutput("PCE",         got.pc,               e.pc);
        checkOutput("PCPlus4E",    got.pc_plus4,         e.pc_plus4);
        if (rst_in) begin
            for (int i = 0; i < 32; i++) model_rf[i] = 32'd0;
        end else if (wen && rdw != 5'd0) begin
            model_rf[rdw] = res;
        end
    endtask

    // Plain instruction with no writeback, flush or reset
    task automatic issue(input logic [31:0] instr);
        applyStimulus(instr, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    endtask

    function automatic logic [31:0] rType(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] iAlu(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        next_pc   = 32'd0;
        rst       = 1'b1;
        InstrD    = 32'h00500093;
        PCD       = 32'd0;
        PCPlus4D  = 32'd4;
        RegWriteW = 1'b0;
        RDW       = 5'd0;
        ResultW   = 32'd0;
        FlushE    = 1'b0;
        for (int i = 0; i < 32; i++) model_rf[i] = 32'd0;

        $display("[TB] reset");
        applyStimulus(32'h00500093, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
        applyStimulus(32'h00500093, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);

        $display("[TB] register file cleared");
        for (int i = 1; i < 32; i++) begin
            issue(rType(7'd0, 5'((i % 31) + 1), 5'(i), 3'b000, 5'd0));
        end

        $display("[TB] addi");
        next_pc = 32'h10;
        issue(32'h00500093);

        $display("[TB] bypass and x0");
        applyStimulus(32'h00000033, 1'b1, 5'd2, 32'h12345678, 1'b0, 1'b0);
        applyStimulus(32'h402081B3, 1'b1, 5'd1, 32'hAAAA5555, 1'b0, 1'b0);
        applyStimulus(32'h00000033, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 1'b0);
        issue(rType(7'd0, 5'd1, 5'd0, 3'b000, 5'd4));
        issue(rType(7'd0, 5'd2, 5'd1, 3'b000, 5'd4));

        $display("[TB] immediates");
        issue(32'hFE20AE23);
        issue(32'hFE208CE3);
        issue(32'h010000EF);

        $display("[TB] ALU decode variants");
        issue(rType(7'h20, 5'd2, 5'd1, 3'b111, 5'd6));
        issue(rType(7'h00, 5'd2, 5'd1, 3'b110, 5'd6));
        issue(rType(7'h00, 5'd2, 5'd1, 3'b010, 5'd6));
        issue(rType(7'h00, 5'd2, 5'd1, 3'b100, 5'd6));
        issue(iAlu(12'hFFF, 5'd1, 3'b000, 5'd7));
        issue(iAlu(12'h400, 5'd2, 3'b000, 5'd7));
        issue(iAlu(12'h7FF, 5'd2, 3'b010, 5'd7));
        issue(iAlu(12'h0F0, 5'd1, 3'b110, 5'd7));
        issue(iAlu(12'h800, 5'd1, 3'b111, 5'd7));
        issue(iAlu(12'h003, 5'd1, 3'b001, 5'd7));
        issue({12'h008, 5'd2, 3'b010, 5'd9, 7'b0000011});

        $display("[TB] flush");
        applyStimulus({12'h000, 5'd5, 3'b010, 5'd6, 7'b0000011}, 1'b1, 5'd5, 32'd7, 1'b1, 1'b0);
        issue(rType(7'd0, 5'd0, 5'd5, 3'b000, 5'd0));

        $display("[TB] unknown opcode and mid-stream reset");
        issue(32'h0000007F);
        issue(32'hFFFFFFFF);
        applyStimulus(32'h402081B3, 1'b1, 5'd8, 32'h55AA55AA, 1'b0, 1'b1);
        issue(rType(7'd0, 5'd8, 5'd5, 3'b000, 5'd0));
        issue(rType(7'd0, 5'd2, 5'd1, 3'b000, 5'd0));

        $display("[TB] %0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/decode_cycle.md
Name: decode_cycle

Overview:
Decode stage of the 5-stage RV32I pipeline. It sits directly downstream of the fetch stage and consumes its InstrD/PCD/PCPlus4D outputs. Each cycle it decodes the instruction, reads the register file (written back from W), and sign-extends the immediate. It then registers all control and data into the ID/EX pipeline register that feeds execute.

Parameters:
- XLEN, 32, datapath width.
- NREGS, 32, architectural register count; index width is 5.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- InstrD  in  32  instruction from the IF/ID register.
- PCD  in  32  PC of InstrD.
- PCPlus4D  in  32  PCD+4.
- RegWriteW  in  1  writeback enable.
- RDW  in  5  writeback destination register.
- ResultW  in  32  writeback data.
- FlushE  in  1  insert a bubble into ID/EX (branch taken / load hazard).
- RegWriteE  out  1  registered control.
- ResultSrcE  out  2  00 ALU, 01 memory, 10 PC+4.
- MemWriteE  out  1  store enable.
- JumpE  out  1  jal.
- BranchE  out  1  beq.
- ALUControlE  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
- ALUSrcE  out  1  1 selects ImmExtE as ALU operand B.
- RD1E  out  32  rs1 data.
- RD2E  out  32  rs2 data.
- ImmExtE  out  32  sign-extended immediate.
- Rs1E  out  5  InstrD[19:15] (for the forwarding unit).
- Rs2E  out  5  InstrD[24:20].
- RdE  out  5  InstrD[11:7].
- PCE  out  32  registered PCD.
- PCPlus4E  out  32  registered PCPlus4D.
- Rs1D  out  5  combinational InstrD[19:15], for the hazard unit.
- Rs2D  out  5  combinational InstrD[24:20], for the hazard unit.

Behaviour:
- Latency: exactly 1 cycle. Inputs sampled at posedge N appear on the *E outputs after posedge N.
- Reset:
  - rst=1 at posedge clears all 32 registers and every *E output to 0.
  - Reset mid-operation discards any in-flight decode; a writeback pending that cycle is dropped.
- Register file:
  - 32x32. x0 always reads 0; writes to x0 are ignored.
  - Write occurs at posedge when RegWriteW=1, RDW!=0 and rst=0.
  - Read bypass: if RegWriteW=1, RDW!=0 and RDW matches rs1 (or rs2) in the same cycle, RD1 (or RD2) returns ResultW. This is a W->D forward inside the same cycle.
- Main decoder, on opcode InstrD[6:0]. Listed values are RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, Branch, ALUOp, Jump:
  - 0000011 lw: 1, I, 1, 0, 01, 0, 00, 0.
  - 0100011 sw: 0, S, 1, 1, xx->00, 0, 00, 0.
  - 0110011 R-type: 1, -, 0, 0, 00, 0, 10, 0.
  - 0010011 I-ALU: 1, I, 1, 0, 00, 0, 10, 0.
  - 1100011 beq: 0, B, 0, 0, 00, 1, 01, 0.
  - 1101111 jal: 1, J, 0, 0, 10, 0, 00, 1.
  - Any other opcode: all controls 0 (acts as a bubble).
- ALU decoder:
  - ALUOp 00 gives add; ALUOp 01 gives sub.
  - ALUOp 10 decodes on funct3: 000 gives sub iff opcode[5]&funct7[5], else add; 010 slt; 110 or; 111 and; any other funct3 gives add.
- Immediate extension (sign bit is always InstrD[31]):
  - I: [31:20].
  - S: {[31:25],[11:7]}.
  - B: {[31],[7],[30:25],[11:8],0}.
  - J: {[31],[19:12],[20],[30:21],0}.
  - ImmExtE=0 for R-type and unknown opcodes.
- ID/EX register priority: rst > FlushE > load.
  - FlushE=1 clears every *E output to 0 at posedge.
  - The register-file write still occurs during a flush.
- No stall input: decode advances every cycle unless flushed or reset.

Test Plan:
- Reset: hold rst=1 for 2 cycles with InstrD=0x00500093. Afterwards all *E outputs are 0, and reading x1..x31 returns 0.
- addi x1,x0,5 (0x00500093), PCD=0x10, PCPlus4D=0x14. Next cycle:
  - RegWriteE=1, ALUSrcE=1, ALUControlE=000, ImmExtE=5, RdE=1, Rs1E=0.
  - PCE=0x10, PCPlus4E=0x14.
- Bypass and x0:
  - Same cycle as sub x3,x1,x2 (0x402081B3), drive RegWriteW=1, RDW=1, ResultW=0xAAAA5555. Expect RD1E=0xAAAA5555 and ALUControlE=001.
  - A write of 0xFFFFFFFF to RDW=0 leaves x0 reading 0.
- Immediates:
  - sw x2,-4(x1) (0xFE20AE23) gives MemWriteE=1, RegWriteE=0, ImmExtE=0xFFFFFFFC.
  - beq x1,x2,-8 (0xFE208CE3) gives BranchE=1, ALUControlE=001, ImmExtE=0xFFFFFFF8.
  - jal x1,+16 (0x010000EF) gives JumpE=1, ResultSrcE=10, ImmExtE=0x10.
- Flush: decode lw with FlushE=1 and RegWriteW=1, RDW=5, ResultW=7. Expect:
  - All *E outputs 0 next cycle.
  - x5 reads 7 afterwards.
- Unknown opcode 0x0000007F: all control outputs 0, ImmExtE=0. Then assert rst mid-stream and check that all outputs clear on the following posedge.
